// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  // Width of the memory latency down-counter; covers MEM_LAT up to 15
  localparam int MEM_LAT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory side signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Requester and memory side
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - DM-priority grant select with IF starvation counter
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   arb_en,
  input  logic   if_req,
  input  logic   dm_req,
  output logic   grant_valid,
  output owner_t grant_owner
);

  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  // DM wins unless IF is alone or has already lost STARVE_MAX times in a row
  always_comb begin
    grant_valid = if_req | dm_req;
    grant_owner = OWN_DM;
    if (if_req && (!dm_req || starve_cnt == CNT_MAX)) begin
      grant_owner = OWN_IF;
    end
  end

  // Count DM grants taken while IF waits; an IF grant clears it, it never passes CNT_MAX
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (arb_en && grant_valid) begin
      if (grant_owner == OWN_IF) begin
        starve_cnt <= '0;
      end else if (if_req && starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory port between IF and DM
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [MEM_LAT_W-1:0] CNT_INIT = MEM_LAT_W'(MEM_LAT - 1);

  state_t               state;
  owner_t               owner;
  logic                 cmd_we;
  logic [MEM_LAT_W-1:0] cnt;

  logic                 grant_valid;
  owner_t               grant_owner;

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clock       (clock),
    .reset       (reset),
    .arb_en      (state == IDLE),
    .if_req      (bus.if_req),
    .dm_req      (bus.dm_req),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Transaction sequencer: latch command, strobe memory once, wait out latency, capture, ack
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      cmd_we        <= 1'b0;
      cnt           <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.if_ack    <= 1'b0;
      bus.dm_rdata  <= '0;
      bus.dm_ack    <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner      <= grant_owner;
            bus.mem_en <= 1'b1;
            bus.busy   <= 1'b1;
            state      <= ISSUE;
            if (grant_owner == OWN_DM) begin
              cmd_we        <= bus.dm_we;
              bus.mem_we    <= bus.dm_we;
              bus.mem_addr  <= bus.dm_addr;
              bus.mem_wdata <= bus.dm_wdata;
            end else begin
              cmd_we       <= 1'b0;
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= bus.if_addr;
            end
          end
        end
        ISSUE: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          cnt        <= CNT_INIT;
          state      <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            if (owner == OWN_IF) begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_ack   <= 1'b1;
            end else begin
              if (!cmd_we) begin
                bus.dm_rdata <= bus.mem_rdata;
              end
              bus.dm_ack <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          bus.if_ack <= 1'b0;
          bus.dm_ack <= 1'b0;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam logic [31:0] WORD4 = 32'h012A4023;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b4 ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(3)
  ) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (b1)
  );

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(4), .STARVE_MAX(3)
  ) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (b4)
  );

  // Single-cycle synchronous memory for the MEM_LAT=1 instance
  logic [31:0] mem1 [64];
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem1[i] <= 32'h0;
      mem1[1] <= WORD4;
      b1.mem_rdata <= 32'h0;
    end else if (b1.mem_en) begin
      if (b1.mem_we) mem1[b1.mem_addr[7:2]] <= b1.mem_wdata;
      else           b1.mem_rdata <= mem1[b1.mem_addr[7:2]];
    end
  end

  // Read-only memory with a 4-stage return pipeline for the MEM_LAT=4 instance
  logic [31:0] pipe4 [4];
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) pipe4[i] <= 32'h0;
    end else begin
      pipe4[0] <= (b4.mem_en && b4.mem_addr[7:2] == 6'd1) ? WORD4 : 32'h0;
      for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
    end
  end
  assign b4.mem_rdata = pipe4[3];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_if;
    logic [31:0] exp_dm;
  } vec_t;

  vec_t vecs [7];

  task automatic run_txn(input vec_t v, input int idx);
    int          lat;
    int          n_en;
    bit          done;
    bit          busy_ok;
    logic        we_seen;
    logic [31:0] addr_seen;
    logic [31:0] wdata_seen;
    lat = 0; n_en = 0; done = 0; busy_ok = 1;
    we_seen = 1'b0; addr_seen = '0; wdata_seen = '0;
    if (v.is_dm) begin
      b1.dm_req = 1'b1; b1.dm_we = v.we; b1.dm_addr = v.addr; b1.dm_wdata = v.wdata;
    end else begin
      b1.if_req = 1'b1; b1.if_addr = v.addr;
    end
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (!b1.busy) busy_ok = 0;
      if (b1.mem_en) begin
        n_en++;
        we_seen = b1.mem_we; addr_seen = b1.mem_addr; wdata_seen = b1.mem_wdata;
      end
      if (b1.if_ack || b1.dm_ack) done = 1;
    end
    check($sformatf("v%0d_latency", idx), lat, 3);
    check($sformatf("v%0d_ack_owner", idx), {b1.dm_ack, b1.if_ack}, v.is_dm ? 2'b10 : 2'b01);
    check($sformatf("v%0d_if_rdata", idx), b1.if_rdata, v.exp_if);
    check($sformatf("v%0d_dm_rdata", idx), b1.dm_rdata, v.exp_dm);
    check($sformatf("v%0d_mem_en_count", idx), n_en, 1);
    check($sformatf("v%0d_mem_we", idx), we_seen, v.we);
    check($sformatf("v%0d_mem_addr", idx), addr_seen, v.addr);
    if (v.we) check($sformatf("v%0d_mem_wdata", idx), wdata_seen, v.wdata);
    check($sformatf("v%0d_busy_span", idx), busy_ok, 1'b1);
    b1.if_req = 1'b0; b1.dm_req = 1'b0;
    tick();
    check($sformatf("v%0d_idle_after", idx), {b1.busy, b1.if_ack, b1.dm_ack, b1.mem_en}, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          n_en;
    int          n_ack;
    bit          done;
    logic [7:0]  order;
    logic [1:0]  got;

    b1.if_req = 0; b1.if_addr = '0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = '0; b1.dm_wdata = '0;
    b4.if_req = 0; b4.if_addr = '0; b4.dm_req = 0; b4.dm_we = 0; b4.dm_addr = '0; b4.dm_wdata = '0;

    vecs[0] = '{1'b0, 1'b0, 32'h4,  32'h0,        WORD4,        32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, WORD4,        32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h10, 32'h0,        WORD4,        32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 32'h20, 32'hCAFEF00D, WORD4,        32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b0, 32'h20, 32'h0,        32'hCAFEF00D, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b0, 32'h4,  32'h0,        32'hCAFEF00D, WORD4};
    vecs[6] = '{1'b0, 1'b0, 32'h8,  32'h0,        32'h0,        WORD4};

    // Reset state
    #20;
    reset = 1'b1;
    #2;
    check("rst_acks", {b1.if_ack, b1.dm_ack}, 2'b00);
    check("rst_rdata", {b1.if_rdata, b1.dm_rdata}, 64'h0);
    check("rst_mem_ctl", {b1.mem_en, b1.mem_we, b1.busy}, 3'b000);
    check("rst_mem_addr", b1.mem_addr, 32'h0);
    check("rst_mem_wdata", b1.mem_wdata, 32'h0);

    // MEM_LAT=4 single read
    @(posedge clock); #1;
    b4.if_req = 1'b1; b4.if_addr = 32'h4;
    lat = 0; n_en = 0; done = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (b4.mem_en) n_en++;
      if (b4.if_ack) done = 1;
    end
    check("lat4_latency", lat, 6);
    check("lat4_mem_en_count", n_en, 1);
    check("lat4_if_rdata", b4.if_rdata, WORD4);
    b4.if_req = 1'b0;
    tick();
    check("lat4_idle_after", {b4.busy, b4.if_ack}, 2'b00);

    // Single-requester vector table
    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // Reset reasserted while in WAIT abandons the transaction
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 32'h10;
    tick();
    tick();
    check("rstwait_in_wait", b1.busy, 1'b1);
    reset = 1'b0;
    #1;
    check("rstwait_busy", {b1.busy, b1.mem_en, b1.dm_ack}, 3'b000);
    check("rstwait_dm_rdata", b1.dm_rdata, 32'h0);
    b1.dm_req = 1'b0;
    #3;
    reset = 1'b1;
    n_ack = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (b1.dm_ack || b1.if_ack) n_ack++;
    end
    check("rstwait_no_ack", n_ack, 0);
    check("rstwait_idle", b1.busy, 1'b0);

    // Both requests held: DM three times, then IF
    order = 8'b0111_0111;
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 32'h10;
    b1.if_req = 1'b1; b1.if_addr = 32'h4;
    for (int g = 0; g < 8; g++) begin
      int k;
      k = 0; got = 2'b00;
      while (got == 2'b00 && k < 10) begin
        tick();
        k++;
        got = {b1.dm_ack, b1.if_ack};
      end
      check($sformatf("starve_grant%0d", g), got, order[g] ? 2'b10 : 2'b01);
    end
    b1.dm_req = 1'b0; b1.if_req = 1'b0;
    tick();
    tick();

    // IF drops its request mid-WAIT: still exactly one ack
    b1.if_req = 1'b1; b1.if_addr = 32'h4;
    tick();
    tick();
    b1.if_req = 1'b0;
    n_ack = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (b1.if_ack) n_ack++;
    end
    check("drop_ack_count", n_ack, 1);
    check("drop_if_rdata", b1.if_rdata, WORD4);
    check("drop_idle", {b1.busy, b1.mem_en}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
